// File: rtl/inta_sequencer.sv
// rtl/inta_sequencer.sv - 8259A-style INTA sequencer: priority resolve, ISR ownership, OCW2/AEOI handling
module inta_sequencer #(
   parameter int NUM_IRQ = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irr,
   input  logic [NUM_IRQ-1:0] imr,
   input  logic               inta,
   input  logic [4:0]         vector_base,
   input  logic               aeoi,
   input  logic               ocw2_wr,
   input  logic [7:0]         ocw2_data,
   output logic               int_out,
   output logic [NUM_IRQ-1:0] isr,
   output logic [NUM_IRQ-1:0] irr_clear,
   output logic [7:0]         data_out,
   output logic               data_oe,
   output logic [2:0]         lowest_prio
);

   typedef enum logic [1:0] {IDLE, REQ, ACK1, ACK2} state_t;

   state_t             state, state_n;
   logic               int_out_n, data_oe_n, rotate_aeoi, rotate_aeoi_n;
   logic               spurious, spurious_n;
   logic [2:0]         lvl, lvl_n, lowest_prio_n;
   logic [7:0]         data_out_n;
   logic [NUM_IRQ-1:0] irr_clear_n, isr_n, isr_set, isr_clr_ocw, isr_clr_aeoi;
   logic [NUM_IRQ-1:0] pend;
   logic [6:0]         win_res, isr_res;
   logic               win_found, isr_found, qualify, ocw2_valid;
   logic [2:0]         win_rank, win_lvl, isr_rank, isr_lvl, ocw_l;

   // Walks levels from highest to lowest priority; returns {found, rank, level}.
   function automatic logic [6:0] resolve(input logic [NUM_IRQ-1:0] bits, input logic [2:0] lp);
      logic       found;
      logic [2:0] rank, level, l;
      found = 1'b0;
      rank  = 3'd0;
      level = 3'd0;
      for (int k = 0; k < NUM_IRQ; k++) begin
         l = lp + 3'd1 + 3'(k);
         if (!found && bits[l]) begin
            found = 1'b1;
            rank  = 3'(k);
            level = l;
         end
      end
      return {found, rank, level};
   endfunction

   assign pend    = irr & ~imr;
   assign win_res = resolve(pend, lowest_prio);
   assign isr_res = resolve(isr, lowest_prio);
   assign {win_found, win_rank, win_lvl} = win_res;
   assign {isr_found, isr_rank, isr_lvl} = isr_res;
   assign qualify = win_found && (!isr_found || (win_rank < isr_rank));

   // Bits 4:3 distinguish OCW2 from OCW3/ICW1 writes sharing the same strobe.
   assign ocw2_valid = ocw2_wr && (ocw2_data[4:3] == 2'b00);
   assign ocw_l      = ocw2_data[2:0];

   always_comb begin
      state_n       = state;
      int_out_n     = int_out;
      irr_clear_n   = '0;
      data_out_n    = data_out;
      data_oe_n     = 1'b0;
      lvl_n         = lvl;
      spurious_n    = spurious;
      lowest_prio_n = lowest_prio;
      rotate_aeoi_n = rotate_aeoi;
      isr_set       = '0;
      isr_clr_ocw   = '0;
      isr_clr_aeoi  = '0;

      if (ocw2_valid) begin
         case (ocw2_data[7:5])
            3'b001: if (isr_found) isr_clr_ocw[isr_lvl] = 1'b1;
            3'b011: isr_clr_ocw[ocw_l] = 1'b1;
            3'b101: if (isr_found) begin
               isr_clr_ocw[isr_lvl] = 1'b1;
               lowest_prio_n        = isr_lvl;
            end
            3'b111: begin
               isr_clr_ocw[ocw_l] = 1'b1;
               lowest_prio_n      = ocw_l;
            end
            3'b110: lowest_prio_n = ocw_l;
            3'b100: rotate_aeoi_n = 1'b1;
            3'b000: rotate_aeoi_n = 1'b0;
            default: ;
         endcase
      end

      case (state)
         IDLE, REQ: begin
            if (inta) begin
               int_out_n = 1'b0;
               state_n   = ACK1;
               if (win_found) begin
                  lvl_n                = win_lvl;
                  spurious_n           = 1'b0;
                  isr_set[win_lvl]     = 1'b1;
                  irr_clear_n[win_lvl] = 1'b1;
               end else begin
                  lvl_n      = 3'd7;
                  spurious_n = 1'b1;
               end
            end else if (state == IDLE) begin
               int_out_n = qualify;
               if (qualify) state_n = REQ;
            end
         end
         ACK1: begin
            if (inta) begin
               data_out_n = {vector_base, lvl};
               data_oe_n  = 1'b1;
               state_n    = ACK2;
            end
         end
         ACK2: begin
            // AEOI rotation is applied after OCW2 so it wins a same-cycle conflict.
            if (aeoi && !spurious) begin
               isr_clr_aeoi[lvl] = 1'b1;
               if (rotate_aeoi) lowest_prio_n = lvl;
            end
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      isr_n = (isr & ~(isr_clr_ocw | isr_clr_aeoi)) | isr_set;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         int_out     <= 1'b0;
         isr         <= '0;
         irr_clear   <= '0;
         data_out    <= 8'h00;
         data_oe     <= 1'b0;
         lowest_prio <= 3'd7;
         rotate_aeoi <= 1'b0;
         lvl         <= 3'd0;
         spurious    <= 1'b0;
      end else begin
         state       <= state_n;
         int_out     <= int_out_n;
         isr         <= isr_n;
         irr_clear   <= irr_clear_n;
         data_out    <= data_out_n;
         data_oe     <= data_oe_n;
         lowest_prio <= lowest_prio_n;
         rotate_aeoi <= rotate_aeoi_n;
         lvl         <= lvl_n;
         spurious    <= spurious_n;
      end
   end

endmodule
